// File: rtl/fpu_exce_writeback_pkg.sv
// Shared FPU constants: op codes, exception codes, special values, sticky flag
// indices and writeback FSM encodings.
package FPU_PACK;

    localparam logic [1:0] _ADDITION       = 2'b00;
    localparam logic [1:0] _SUBTRACTION    = 2'b01;
    localparam logic [1:0] _MULTIPLICATION = 2'b10;
    localparam logic [1:0] _DIVISION       = 2'b11;

    localparam logic [2:0] _NO_EXCE       = 3'd0;
    localparam logic [2:0] _qNAN_EXCE     = 3'd1;
    localparam logic [2:0] _sNAN_EXCE     = 3'd2;
    localparam logic [2:0] _INF_EXCE      = 3'd3;
    localparam logic [2:0] _ZERO_DIV_EXCE = 3'd4;

    localparam logic [7:0] _CANON_QNAN = 8'h7C;
    localparam logic [7:0] _PLUS_INF   = 8'h78;
    localparam logic [7:0] _MINUS_INF  = 8'hF8;

    localparam int _FLG_INV  = 0;
    localparam int _FLG_DZ   = 1;
    localparam int _FLG_QNAN = 2;

    typedef enum logic {
        _WB_RUN     = 1'b0,
        _WB_TRAPPED = 1'b1
    } wb_state_e;

    // FIFO entry: exception code above the 8-bit result.
    typedef struct packed {
        logic [2:0] exce;
        logic [7:0] result;
    } wb_entry_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; head reads as zero while empty.
module fpu_result_fifo #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; emptiness masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fpu_exce_writeback.sv
// FPU writeback: special-value selection, result FIFO, sticky flags, sNaN trap.
// Define FPU_EXCE_COUNT_EN to add the saturating EXCE_COUNT output.
module fpu_exce_writeback
    import FPU_PACK::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [1:0] FP_OPERATION,
    input  logic [7:0] OP_A,
    input  logic [7:0] OP_B,
    input  logic [7:0] ARITH_RESULT,
    input  logic       OP_IS_EXCEPTION,
    input  logic [2:0] FP_EXCE,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [7:0] RESULT,
    output logic [2:0] RESULT_EXCE,
    output logic [2:0] STICKY_FLAGS,
    input  logic       FLAG_CLR,
`ifdef FPU_EXCE_COUNT_EN
    output logic [7:0] EXCE_COUNT,
`endif
    output logic       TRAP,
    input  logic       TRAP_ACK
);

    wb_state_e  state_q, state_d;
    logic [2:0] flags_q, flags_d;
    wb_entry_t  sel_entry, head_entry;
    logic       fifo_full, fifo_empty;
    logic       accept, pop;
    logic       a_is_zero;
    logic       unused_inputs;

    // The op code and B magnitude carry no information this stage needs.
    assign unused_inputs = ^{FP_OPERATION, OP_B[6:0]};

    assign IN_READY  = (state_q == _WB_RUN) && !fifo_full;
    assign accept    = IN_VALID && IN_READY;
    assign OUT_VALID = !fifo_empty;
    assign pop       = OUT_VALID && OUT_READY;
    assign a_is_zero = (OP_A[6:0] == 7'd0);

    always_comb begin
        sel_entry.result = ARITH_RESULT;
        sel_entry.exce   = _NO_EXCE;
        if (OP_IS_EXCEPTION) begin
            sel_entry.exce = FP_EXCE;
            case (FP_EXCE)
                _qNAN_EXCE, _sNAN_EXCE, _INF_EXCE: sel_entry.result = _CANON_QNAN;
                _ZERO_DIV_EXCE: begin
                    if (a_is_zero) begin
                        // 0/0 is an invalid operation, not a divide-by-zero
                        sel_entry.result = _CANON_QNAN;
                        sel_entry.exce   = _INF_EXCE;
                    end else begin
                        sel_entry.result = (OP_A[7] ^ OP_B[7]) ? _MINUS_INF : _PLUS_INF;
                    end
                end
                default: sel_entry.result = ARITH_RESULT;
            endcase
        end
    end

    fpu_result_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (accept),
        .pop   (pop),
        .wdata (sel_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign RESULT      = head_entry.result;
    assign RESULT_EXCE = head_entry.exce;

    // Sets are applied after the clear so a same-cycle set survives.
    always_comb begin
        flags_d = FLAG_CLR ? 3'b000 : flags_q;
        if (accept) begin
            if (sel_entry.exce == _sNAN_EXCE || sel_entry.exce == _INF_EXCE)
                flags_d[_FLG_INV] = 1'b1;
            if (sel_entry.exce == _ZERO_DIV_EXCE)
                flags_d[_FLG_DZ] = 1'b1;
            if (sel_entry.exce == _qNAN_EXCE)
                flags_d[_FLG_QNAN] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            _WB_RUN:     if (accept && sel_entry.exce == _sNAN_EXCE) state_d = _WB_TRAPPED;
            _WB_TRAPPED: if (TRAP_ACK) state_d = _WB_RUN;
            default:     state_d = _WB_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= _WB_RUN;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    assign STICKY_FLAGS = flags_q;
    assign TRAP         = (state_q == _WB_TRAPPED);

`ifdef FPU_EXCE_COUNT_EN
    logic [7:0] exce_count_q, exce_count_d;

    always_comb begin
        exce_count_d = FLAG_CLR ? 8'd0 : exce_count_q;
        if (accept && sel_entry.exce != _NO_EXCE && exce_count_d != 8'hFF)
            exce_count_d = exce_count_d + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) exce_count_q <= 8'd0;
        else        exce_count_q <= exce_count_d;
    end

    assign EXCE_COUNT = exce_count_q;
`endif

endmodule
